// File: rtl/timer_seq_ctrl_if.sv
// Counter-side bus of the mm:ss timer sequencer.
// The sequencer is master; the counter instance is slave.
interface timer_seq_ctrl_if;
  logic        sec_tick;
  logic [15:0] digits;
  logic        cnt_ent;
  logic        cnt_up_down;
  logic        cnt_load;
  logic        cnt_clear;
  logic        cnt_en_bu;

  modport master (
    input  sec_tick,
    input  digits,
    output cnt_ent,
    output cnt_up_down,
    output cnt_load,
    output cnt_clear,
    output cnt_en_bu
  );

  modport slave (
    output sec_tick,
    output digits,
    input  cnt_ent,
    input  cnt_up_down,
    input  cnt_load,
    input  cnt_clear,
    input  cnt_en_bu
  );
endinterface

// File: rtl/timer_seq_ctrl.sv
// Key debounce plus IDLE/SET/RUN/PAUSE/ALARM sequencer
// driving the mm:ss counter controls.
module timer_seq_ctrl #(
  parameter int DEB_CYCLES = 270000,
  parameter int ALARM_SECS = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_mode_n,
  input  logic              key_start_n,
  input  logic              dir_sw,
  timer_seq_ctrl_if.master  bus,
  output logic              alarm,
  output logic [2:0]        state
);

  localparam int CW =
    (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] DEB_MAX =
    CW'(DEB_CYCLES - 1);
  localparam logic [7:0] ALARM_LAST =
    8'(ALARM_SECS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SET   = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    ALARM = 3'd4
  } st_t;

  // bit 0 = START, bit 1 = MODE
  logic [1:0]    sync1, sync2, deb, press;
  logic [CW-1:0] dcnt [2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1   <= 2'b11;
      sync2   <= 2'b11;
      deb     <= 2'b11;
      press   <= 2'b00;
      dcnt[0] <= '0;
      dcnt[1] <= '0;
    end else begin
      sync1 <= {key_mode_n, key_start_n};
      sync2 <= sync1;
      press <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == deb[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DEB_MAX) begin
          deb[i]   <= sync2[i];
          dcnt[i]  <= '0;
          press[i] <= ~sync2[i];
        end else begin
          dcnt[i] <= dcnt[i] + 1'b1;
        end
      end
    end
  end

  logic start_ev, mode_ev;
  assign start_ev = press[0];
  assign mode_ev  = press[1];

  st_t        st_q, st_d;
  logic       ud_q, ud_d;
  logic [1:0] mask_q, mask_d;
  logic [7:0] acnt_q, acnt_d;
  logic       load_q, load_d;
  logic       clear_q, clear_d;
  logic       ent_q, bu_q, alarm_q;
  logic       term;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q    <= IDLE;
      ud_q    <= 1'b0;
      mask_q  <= 2'd0;
      acnt_q  <= 8'd0;
      load_q  <= 1'b0;
      clear_q <= 1'b0;
      ent_q   <= 1'b0;
      bu_q    <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      st_q    <= st_d;
      ud_q    <= ud_d;
      mask_q  <= mask_d;
      acnt_q  <= acnt_d;
      load_q  <= load_d;
      clear_q <= clear_d;
      ent_q   <= (st_d == RUN);
      bu_q    <= (st_d == SET);
      alarm_q <= (st_d == ALARM);
    end
  end

  // mask hides stale digits until a load/clear lands
  always_comb begin
    st_d    = st_q;
    ud_d    = ud_q;
    mask_d  = (mask_q != 2'd0) ? mask_q - 2'd1 : 2'd0;
    acnt_d  = acnt_q;
    load_d  = 1'b0;
    clear_d = 1'b0;
    term    = (mask_q == 2'd0) &&
              (ud_q ? (bus.digits == 16'h0000)
                    : (bus.digits == 16'h5959));
    unique case (st_q)
      IDLE: begin
        if (start_ev) begin
          st_d    = RUN;
          mask_d  = 2'd3;
          ud_d    = dir_sw;
          load_d  = dir_sw;
          clear_d = ~dir_sw;
        end else if (mode_ev) begin
          st_d = SET;
        end
      end
      SET: begin
        if (start_ev) begin
          st_d   = RUN;
          mask_d = 2'd3;
          ud_d   = dir_sw;
          load_d = 1'b1;
        end else if (mode_ev) begin
          st_d = IDLE;
        end
      end
      RUN: begin
        if (start_ev) begin
          st_d = PAUSE;
        end else if (term) begin
          st_d   = ALARM;
          acnt_d = 8'd0;
        end
      end
      PAUSE: begin
        if (start_ev) begin
          st_d   = RUN;
          mask_d = 2'd0;
        end else if (mode_ev) begin
          st_d = IDLE;
        end
      end
      ALARM: begin
        if (start_ev || mode_ev) begin
          st_d = IDLE;
        end else if (bus.sec_tick) begin
          if (acnt_q == ALARM_LAST) st_d = IDLE;
          else acnt_d = acnt_q + 8'd1;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  assign bus.cnt_ent     = ent_q;
  assign bus.cnt_up_down = ud_q;
  assign bus.cnt_load    = load_q;
  assign bus.cnt_clear   = clear_q;
  assign bus.cnt_en_bu   = bu_q;
  assign alarm           = alarm_q;
  assign state           = st_q;

endmodule

// File: tb/tb_timer_seq_ctrl.sv
// Scoreboard bench for timer_seq_ctrl with DEB_CYCLES=4.
// Stimulus queues expected outputs per cycle; a monitor checks them.
module tb_timer_seq_ctrl;

  logic clk = 1'b0;
  logic reset;
  logic key_mode_n, key_start_n, dir_sw;
  logic alarm;
  logic [2:0] state;

  timer_seq_ctrl_if bus ();

  timer_seq_ctrl #(
    .DEB_CYCLES (4),
    .ALARM_SECS (10)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .key_mode_n  (key_mode_n),
    .key_start_n (key_start_n),
    .dir_sw      (dir_sw),
    .bus         (bus.master),
    .alarm       (alarm),
    .state       (state)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [8:0] val;
    string      name;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   done    = 1'b0;

  logic [8:0] obs;
  assign obs = {state, alarm, bus.cnt_en_bu, bus.cnt_clear,
                bus.cnt_load, bus.cnt_up_down, bus.cnt_ent};

  function automatic logic [8:0] mk(input logic [2:0] st,
                                    input logic [5:0] flags);
    return {st, flags};
  endfunction

  task automatic expect_at(input int d, input logic [8:0] v,
                           input string nm);
    exp_t e;
    e.cyc  = cyc + d;
    e.val  = v;
    e.name = nm;
    q.push_back(e);
  endtask

  task automatic check_now(input logic [8:0] v,
                           input string nm);
    n_tests++;
    if (obs !== v) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %b want %b",
               nm, cyc, obs, v);
    end
  endtask

  always @(negedge clk) begin
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (done || q[i].cyc <= cyc) begin
        n_tests++;
        if (done || q[i].cyc < cyc || obs !== q[i].val) begin
          n_fail++;
          $display("FAIL %s cycle %0d: got %b want %b (at cycle %0d)",
                   q[i].name, cyc, obs, q[i].val, q[i].cyc);
        end
        q.delete(i);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input bit s, input bit m, input int hold);
    if (s) key_start_n = 1'b0;
    if (m) key_mode_n  = 1'b0;
    step(hold);
    key_start_n = 1'b1;
    key_mode_n  = 1'b1;
    step(10);
  endtask

  initial begin
    reset       = 1'b1;
    key_mode_n  = 1'b1;
    key_start_n = 1'b1;
    dir_sw      = 1'b0;
    bus.digits  = 16'h1234;
    bus.sec_tick = 1'b0;
    step(2);
    check_now(mk(3'd0, 6'b000000), "reset_now");
    expect_at(1, mk(3'd0, 6'b000000), "reset_state");
    step(1);
    reset = 1'b0;
    step(2);

    key_start_n = 1'b0;
    expect_at(7, mk(3'd0, 6'b000000), "glitch_a");
    expect_at(12, mk(3'd0, 6'b000000), "glitch_b");
    step(3);
    key_start_n = 1'b1;
    step(12);

    expect_at(6, mk(3'd0, 6'b000000), "deb_pre");
    expect_at(7, mk(3'd2, 6'b001001), "deb_clear");
    expect_at(8, mk(3'd2, 6'b000001), "deb_run");
    expect_at(30, mk(3'd2, 6'b000001), "one_event");
    press(1, 0, 20);

    bus.digits = 16'h5959;
    expect_at(1, mk(3'd4, 6'b100000), "up_term");
    step(3);
    expect_at(6, mk(3'd4, 6'b100000), "alarm_hold");
    expect_at(7, mk(3'd0, 6'b000000), "alarm_mode");
    press(0, 1, 8);

    dir_sw = 1'b1;
    bus.digits = 16'h0500;
    step(1);
    expect_at(7, mk(3'd2, 6'b000111), "dn_load");
    expect_at(8, mk(3'd2, 6'b000011), "dn_run");
    press(1, 0, 8);
    bus.digits = 16'h0001;
    expect_at(1, mk(3'd2, 6'b000011), "dn_0001");
    step(1);
    bus.digits = 16'h0000;
    expect_at(1, mk(3'd4, 6'b100010), "dn_term");
    step(2);
    for (int i = 1; i <= 10; i++) begin
      bus.sec_tick = 1'b1;
      if (i == 10)
        expect_at(1, mk(3'd0, 6'b000010), "tick_exit");
      else
        expect_at(1, mk(3'd4, 6'b100010), "tick_hold");
      step(1);
      bus.sec_tick = 1'b0;
      step(2);
    end
    check_now(mk(3'd0, 6'b000010), "wait_expired");

    expect_at(7, mk(3'd2, 6'b000111), "z_load");
    expect_at(10, mk(3'd2, 6'b000011), "z_masked");
    expect_at(11, mk(3'd4, 6'b100010), "z_alarm");
    press(1, 0, 8);
    expect_at(7, mk(3'd0, 6'b000010), "alarm_start");
    press(1, 0, 8);

    key_start_n = 1'b0;
    expect_at(7, mk(3'd2, 6'b000111), "m_load");
    expect_at(11, mk(3'd2, 6'b000011), "m_0130");
    expect_at(14, mk(3'd2, 6'b000011), "m_count");
    step(9);
    bus.digits = 16'h0130;
    step(3);
    key_start_n = 1'b1;
    step(10);

    expect_at(7, mk(3'd3, 6'b000010), "pause");
    press(1, 0, 8);
    dir_sw = 1'b0;
    bus.digits = 16'h0000;
    expect_at(3, mk(3'd3, 6'b000010), "pause_hold");
    step(4);
    expect_at(7, mk(3'd2, 6'b000011), "resume");
    expect_at(8, mk(3'd4, 6'b100010), "resume_term");
    press(1, 0, 8);
    expect_at(7, mk(3'd0, 6'b000010), "alarm_exit2");
    press(1, 0, 8);

    bus.digits = 16'h0130;
    expect_at(7, mk(3'd2, 6'b001001), "e_clear");
    press(1, 0, 8);
    expect_at(7, mk(3'd3, 6'b000000), "e_pause");
    press(1, 0, 8);
    expect_at(7, mk(3'd0, 6'b000000), "e_idle");
    press(0, 1, 8);
    expect_at(7, mk(3'd1, 6'b010000), "e_set");
    press(0, 1, 8);
    dir_sw = 1'b1;
    expect_at(7, mk(3'd2, 6'b000111), "both_load");
    expect_at(8, mk(3'd2, 6'b000011), "both_run");
    press(1, 1, 8);
    expect_at(7, mk(3'd2, 6'b000011), "mode_ignored");
    press(0, 1, 8);

    key_start_n = 1'b0;
    step(3);
    reset = 1'b1;
    expect_at(0, mk(3'd0, 6'b000000), "rst_async");
    step(2);
    reset = 1'b0;
    expect_at(6, mk(3'd0, 6'b000000), "rst_redeb");
    expect_at(7, mk(3'd2, 6'b000111), "rst_event");
    step(8);
    key_start_n = 1'b1;
    step(10);

    done = 1'b1;
    step(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
